// File: rtl/d0_drain_if.sv
// FIFO-side and downstream-side signals of the D0 drain controller.
// The master modport is the controller; the slave modport is the FIFO/consumer environment.
interface d0_drain_if #(
    parameter int data_width = 6
);
    logic                  empty_fifo_D0;
    logic                  error_D0;
    logic [data_width-1:0] data_out_D0;
    logic                  rd_enable;
    logic                  dn_pause;
    logic                  valid_out;
    logic [data_width-1:0] data_out;

    modport master (
        input  empty_fifo_D0, error_D0, data_out_D0, dn_pause,
        output rd_enable, valid_out, data_out
    );

    modport slave (
        output empty_fifo_D0, error_D0, data_out_D0, dn_pause,
        input  rd_enable, valid_out, data_out
    );
endinterface

// File: rtl/d0_drain_ctrl.sv
// Drains the D0 FIFO into a downstream port in bursts of at most burst_len pops,
// honouring downstream pause and latching FIFO overflow into a sticky error state.
//
// state | meaning
// IDLE  | waiting for enable with a non-empty FIFO
// DRAIN | popping one word per cycle while allowed
// PAUSE | downstream backpressure, no pops
// GAP   | mandatory single idle cycle after a full burst
// ERROR | FIFO overflow seen; held until err_clr with overflow gone
module d0_drain_ctrl #(
    parameter int data_width = 6,
    parameter int burst_len  = 4,
    parameter int cnt_width  = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 err_clr,
    d0_drain_if.master           bus,
    output logic [cnt_width-1:0] pop_count,
    output logic                 busy,
    output logic                 err_out
);
    localparam int bw = $clog2(burst_len + 1);

    typedef enum logic [2:0] {IDLE, DRAIN, PAUSE, GAP, ERROR} state_t;

    state_t          state;
    state_t          state_next;
    logic [bw-1:0]   burst_cnt;
    logic            pop;
    logic            burst_last;

    assign burst_last = (burst_cnt == bw'(burst_len - 1));

    always_comb begin
        pop        = (state == DRAIN) && !bus.empty_fifo_D0 && !bus.dn_pause && !bus.error_D0;
        state_next = state;
        if (bus.error_D0) begin
            state_next = ERROR;
        end else begin
            case (state)
                IDLE:  if (enable && !bus.empty_fifo_D0) state_next = DRAIN;
                DRAIN: begin
                    // A pop on the cycle enable drops still goes out; only the next one is blocked.
                    if (!enable)                  state_next = IDLE;
                    else if (bus.dn_pause)        state_next = PAUSE;
                    else if (pop && burst_last)   state_next = GAP;
                    else if (bus.empty_fifo_D0)   state_next = IDLE;
                end
                PAUSE: begin
                    if (!enable)                  state_next = IDLE;
                    else if (!bus.dn_pause)       state_next = DRAIN;
                end
                GAP:   state_next = enable ? DRAIN : IDLE;
                ERROR: if (err_clr)               state_next = IDLE;
                default:                          state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state         <= IDLE;
            burst_cnt     <= '0;
            pop_count     <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            state         <= state_next;
            bus.valid_out <= pop;
            if (pop) pop_count <= pop_count + cnt_width'(1);
            if (state_next == IDLE || state_next == GAP) burst_cnt <= '0;
            else if (pop)                                 burst_cnt <= burst_cnt + bw'(1);
        end
    end

    assign bus.rd_enable = pop;
    assign bus.data_out  = bus.valid_out ? bus.data_out_D0 : '0;
    assign busy          = (state == DRAIN);
    assign err_out       = (state == ERROR);
endmodule

// File: tb/tb_d0_drain_ctrl.sv
// Scoreboard bench for d0_drain_ctrl: a queue-based FIFO model feeds the DUT,
// every word written is expected downstream in order, and a monitor checks deliveries.
module tb_d0_drain_ctrl;
    localparam int dw = 6;
    localparam int bl = 4;
    localparam int cw = 8;
    localparam int depth = 512;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          enable;
    logic          err_clr;
    logic [cw-1:0] pop_count;
    logic          busy;
    logic          err_out;

    d0_drain_if #(.data_width(dw)) dif ();

    d0_drain_ctrl #(.data_width(dw), .burst_len(bl), .cnt_width(cw)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .enable    (enable),
        .err_clr   (err_clr),
        .bus       (dif.master),
        .pop_count (pop_count),
        .busy      (busy),
        .err_out   (err_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int popped = 0;
    int rd_ptr = 0;
    int wr_ptr = 0;
    logic [dw-1:0] mem [depth];
    logic [dw-1:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: read data appears the cycle after a pop, zero otherwise.
    assign dif.empty_fifo_D0 = (rd_ptr == wr_ptr);
    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dif.data_out_D0 <= '0;
        end else if (dif.rd_enable && rd_ptr != wr_ptr) begin
            dif.data_out_D0 <= mem[rd_ptr % depth];
            rd_ptr          <= rd_ptr + 1;
        end else begin
            dif.data_out_D0 <= '0;
        end
    end

    task automatic write_word(input logic [dw-1:0] d);
        mem[wr_ptr % depth] = d;
        wr_ptr = wr_ptr + 1;
        sb.push_back(d);
    endtask

    // Monitor: each delivered word must be the oldest one still expected.
    always @(negedge clk) begin
        if (reset_L) begin
            if (dif.valid_out) begin
                popped++;
                if (sb.size() == 0) begin
                    chk("unexpected_valid_out", 32'(dif.data_out), 32'hdead);
                end else begin
                    chk("data_out", 32'(dif.data_out), 32'(sb.pop_front()));
                end
            end else begin
                chk("data_out_zero_when_idle", 32'(dif.data_out), 32'h0);
            end
        end
    end

    // Pop rules: pops only in the drain state with data, no pause, no error; burst length bounded.
    int run = 0;
    always @(negedge clk) begin
        #2;
        if (reset_L) begin
            if (dif.rd_enable) begin
                run++;
                chk("rd_enable_legal", 32'(busy && !dif.empty_fifo_D0 && !dif.dn_pause && !dif.error_D0), 32'h1);
                chk("burst_run_len", 32'(run <= bl), 32'h1);
            end else begin
                run = 0;
            end
        end else begin
            run = 0;
        end
    end

    task automatic wait_idle(input string name, input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && rd_ptr == wr_ptr && !dif.valid_out && !dif.rd_enable) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_drain_timeout"}, 32'(done), 32'h1);
        repeat (2) @(negedge clk);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'h0);
        chk({name, "_pop_count"}, 32'(pop_count), 32'(popped % 256));
    endtask

    task automatic capture(input int n, output logic [15:0] pat);
        bit found = 1'b0;
        pat = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dif.rd_enable) begin
                found = 1'b1;
                break;
            end
        end
        chk("capture_first_pop_seen", 32'(found), 32'h1);
        pat = 16'h1;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            pat = {pat[14:0], dif.rd_enable};
        end
    endtask

    task automatic wait_pops(input int n);
        int seen = 0;
        for (int i = 0; i < 40 && seen < n; i++) begin
            @(negedge clk);
            if (dif.rd_enable) seen++;
        end
        chk("wait_pops_reached", 32'(seen), 32'(n));
    endtask

    logic [15:0] pat;

    initial begin
        reset_L      = 1'b0;
        enable       = 1'b0;
        err_clr      = 1'b0;
        dif.error_D0 = 1'b0;
        dif.dn_pause = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_enable", 32'(dif.rd_enable), 32'h0);
        chk("rst_valid_out", 32'(dif.valid_out), 32'h0);
        chk("rst_data_out",  32'(dif.data_out), 32'h0);
        chk("rst_pop_count", 32'(pop_count), 32'h0);
        chk("rst_busy",      32'(busy), 32'h0);
        chk("rst_err_out",   32'(err_out), 32'h0);
        reset_L = 1'b1;
        @(negedge clk);

        // Three words drained back to back.
        enable = 1'b1;
        write_word(6'h11); write_word(6'h22); write_word(6'h33);
        capture(4, pat);
        chk("three_word_rd_pattern", 32'(pat[3:0]), 32'b1110);
        wait_idle("three_word", 100);
        chk("three_word_count", 32'(pop_count), 32'd3);
        chk("three_word_busy", 32'(busy), 32'h0);
        chk("three_word_err", 32'(err_out), 32'h0);

        // Six words: full burst, one gap cycle, then the rest.
        for (int i = 0; i < 6; i++) write_word(6'($urandom_range(0, 63)));
        capture(8, pat);
        chk("burst_gap_pattern", 32'(pat[7:0]), 32'b11110110);
        wait_idle("burst_gap", 100);
        chk("burst_gap_count", 32'(pop_count), 32'd9);

        // Downstream pause right after the second pop.
        for (int i = 0; i < 5; i++) write_word(6'($urandom_range(0, 63)));
        wait_pops(2);
        @(negedge clk);
        chk("pause_inflight_valid", 32'(dif.valid_out), 32'h1);
        dif.dn_pause = 1'b1;
        repeat (3) begin
            #1 chk("pause_no_pop", 32'(dif.rd_enable), 32'h0);
            @(negedge clk);
        end
        dif.dn_pause = 1'b0;
        wait_idle("pause", 100);

        // Overflow error mid-drain.
        for (int i = 0; i < 4; i++) write_word(6'($urandom_range(0, 63)));
        wait_pops(1);
        @(negedge clk);
        dif.error_D0 = 1'b1;
        #1 chk("err_gates_pop", 32'(dif.rd_enable), 32'h0);
        @(negedge clk);
        chk("err_out_set", 32'(err_out), 32'h1);
        dif.error_D0 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("err_hold_no_pop", 32'(dif.rd_enable), 32'h0);
            chk("err_hold_err_out", 32'(err_out), 32'h1);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_err_out", 32'(err_out), 32'h0);
        chk("err_clr_idle", 32'(busy), 32'h0);
        wait_idle("error", 100);

        // Randomized writes, pauses and enable toggling.
        for (int it = 0; it < 40; it++) begin
            int k = $urandom_range(0, 7);
            for (int j = 0; j < k; j++) write_word(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            for (int c = 0; c < $urandom_range(1, 6); c++) begin
                dif.dn_pause = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        dif.dn_pause = 1'b0;
        enable       = 1'b1;
        wait_idle("random", 1000);

        // Asynchronous reset between edges while a word is in flight.
        for (int i = 0; i < 4; i++) write_word(6'($urandom_range(0, 63)));
        wait_pops(1);
        @(posedge clk);
        #2 reset_L = 1'b0;
        wr_ptr = rd_ptr;
        sb.delete();
        popped = 0;
        #1;
        chk("async_rst_valid_out", 32'(dif.valid_out), 32'h0);
        chk("async_rst_data_out", 32'(dif.data_out), 32'h0);
        chk("async_rst_rd_enable", 32'(dif.rd_enable), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_pop_count", 32'(pop_count), 32'h0);
        @(negedge clk);
        write_word(6'h2a);
        reset_L = 1'b1;
        #1 chk("post_rst_no_early_pop", 32'(dif.rd_enable), 32'h0);
        wait_idle("post_rst", 100);

        // Counter wrap: 255 pops total, then one more.
        for (int i = 0; i < 254; i++) write_word(6'($urandom_range(0, 63)));
        wait_idle("wrap_255", 2000);
        chk("wrap_at_255", 32'(pop_count), 32'd255);
        write_word(6'h3f);
        wait_idle("wrap_0", 100);
        chk("wrap_to_0", 32'(pop_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/d0_drain_ctrl.md
D0_DRAIN_CTRL -- requirements
Module: d0_drain_ctrl

Interface
REQ-001 Parameter: data_width, default 6, width of FIFO data words.
REQ-002 Parameter: burst_len, default 4, maximum pops per burst before a mandatory one-cycle gap.
REQ-003 Parameter: cnt_width, default 8, width of pop_count.
REQ-004 Port: clk  input  1  sole clock; all flops rising-edge.
REQ-005 Port: reset_L  input  1  asynchronous, active-low reset.
REQ-006 Port: enable  input  1  level; 1 = drain permitted.
REQ-007 Port: err_clr  input  1  single-cycle pulse; clears the ERROR state.
REQ-008 Port: empty_fifo_D0  input  1  FIFO empty flag (combinational from FIFO count).
REQ-009 Port: error_D0  input  1  FIFO overflow flag.
REQ-010 Port: data_out_D0  input  data_width  FIFO read data; valid the cycle after rd_enable, 0 otherwise.
REQ-011 Port: dn_pause  input  1  downstream backpressure; 1 = no new pops.
REQ-012 Port: rd_enable  output  1  FIFO pop strobe, combinational from state and inputs.
REQ-013 Port: valid_out  output  data_width-independent 1  downstream data-valid strobe.
REQ-014 Port: data_out  output  data_width  downstream data.
REQ-015 Port: pop_count  output  cnt_width  total words popped since reset.
REQ-016 Port: busy  output  1  1 when state is DRAIN.
REQ-017 Port: err_out  output  1  1 when state is ERROR.

Function
REQ-018 States SHALL be IDLE, DRAIN, PAUSE, GAP, ERROR, held in a registered state variable.
REQ-019 rd_enable SHALL be 1 only when state==DRAIN && !empty_fifo_D0 && !dn_pause && !error_D0.
REQ-020 IDLE->DRAIN when enable==1 && !empty_fifo_D0; otherwise remain in IDLE.
REQ-021 DRAIN->PAUSE when dn_pause==1; PAUSE->DRAIN when dn_pause==0 && enable==1; PAUSE->IDLE when enable==0.
REQ-022 DRAIN->IDLE when enable==0, or when empty_fifo_D0==1 and no pop is issued this cycle.
REQ-023 A burst counter SHALL increment on each pop and clear on entry to IDLE or GAP; a pop that brings it to burst_len SHALL cause DRAIN->GAP.
REQ-024 GAP SHALL last exactly one cycle with rd_enable=0, then go to DRAIN if enable==1, else to IDLE.
REQ-025 Any state->ERROR when error_D0==1; ERROR SHALL take priority over all other transitions.
REQ-026 ERROR->IDLE only on err_clr==1 && error_D0==0; rd_enable SHALL be 0 in ERROR.
REQ-027 valid_out SHALL be a flop of rd_enable (latency one cycle); data_out SHALL equal data_out_D0 when valid_out==1, else 0.
REQ-028 pop_count SHALL increment by 1 on every cycle rd_enable==1 and wrap from 2^cnt_width-1 to 0.
REQ-029 When dn_pause rises in the cycle after a pop, that word's valid_out/data_out SHALL still be presented; there is no stalling of in-flight data.
REQ-030 When enable falls, the pop issued in the previous cycle SHALL still complete on valid_out.

Reset
REQ-031 While reset_L==0, state=IDLE, burst counter=0, pop_count=0, valid_out=0, data_out=0, rd_enable=0, busy=0, err_out=0, regardless of clk.
REQ-032 Reset asserted mid-burst SHALL abort immediately; the in-flight word SHALL be discarded (valid_out=0).
REQ-033 After reset_L rises, the first pop SHALL occur no earlier than the first rising edge of clk.

Verification
REQ-034 FIFO holds 3 words 0x11,0x22,0x33; enable=1 -> rd_enable high for 3 consecutive cycles; valid_out high 1 cycle later with data 0x11,0x22,0x33; pop_count=3; state=IDLE.
REQ-035 FIFO holds 6 words, burst_len=4 -> 4 pops, 1 gap cycle with rd_enable=0, 2 pops; pop_count=6.
REQ-036 dn_pause=1 after the 2nd pop for 3 cycles -> 2nd word still output, no pops for 3 cycles, draining resumes; all words delivered in order, none lost.
REQ-037 error_D0 pulse mid-drain -> err_out=1 next cycle, rd_enable=0 until err_clr; after err_clr, state=IDLE, err_out=0.
REQ-038 255 pops then 1 more (cnt_width=8) -> pop_count wraps to 0.
REQ-039 reset_L low asynchronously between edges during a burst -> all outputs 0 immediately; the in-flight word is not output.
